// File: rtl/sa_ram_pkg.sv
// Shared constants and types for the scratch RAM read path.
package sa_ram_pkg;
  localparam int SA_RAM_AW = 5;
  localparam int SA_RAM_DW = 768;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } rd_state_e;

  typedef struct packed {
    logic                 last;
    logic [SA_RAM_DW-1:0] data;
  } obuf_entry_t;
endpackage

// File: rtl/sa_rd_obuf.sv
// Small output FIFO for captured RAM words; push and pop may coincide.
module sa_rd_obuf
  import sa_ram_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = $bits(obuf_entry_t),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  output logic [CW-1:0] count_o,
  output logic [W-1:0]  head_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(push_i) - CW'(pop_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entries reset to zero so the head reads as all-zero out of reset.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mem_q[gi] <= '0;
      end else if (push_i && (wr_ptr_q == PW'(gi))) begin
        mem_q[gi] <= push_data_i;
      end
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
endmodule

// File: rtl/sa_ram_rd_ctrl_32x768.sv
// Burst read sequencer: drives the RAM read port with credit-based flow control
// and streams captured words out through a small buffer.
module sa_ram_rd_ctrl_32x768
  import sa_ram_pkg::*;
#(
  parameter int AW         = SA_RAM_AW,
  parameter int DW         = SA_RAM_DW,
  parameter int OBUF_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [AW:0]   req_len,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic [AW-1:0] ra,
  output logic          re,
  input  logic [DW-1:0] dout
);
  localparam int CW = $clog2(OBUF_DEPTH + 1);

  rd_state_e     state_q, state_d;
  logic [AW-1:0] cur_addr_q, cur_addr_d;
  logic [AW:0]   remaining_q, remaining_d;
  logic          inflight_q, inflight_d;
  logic          inflight_last_q, inflight_last_d;

  logic [CW-1:0] count;
  logic          pop;
  logic          credit;
  obuf_entry_t   wr_entry, rd_entry;

  assign pop       = out_valid && out_ready;
  // A slot freed by this cycle's pop can be reused by this cycle's read.
  assign credit    = (({1'b0, count} + (CW+1)'(inflight_q)) < (CW+1)'(OBUF_DEPTH)) || pop;
  assign req_ready = (state_q == IDLE) && !rst;

  always_comb begin
    state_d         = state_q;
    cur_addr_d      = cur_addr_q;
    remaining_d     = remaining_q;
    re              = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          cur_addr_d  = req_addr;
          remaining_d = (req_len == '0) ? {1'b1, {AW{1'b0}}} : req_len;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (credit) begin
          re          = 1'b1;
          cur_addr_d  = cur_addr_q + AW'(1);
          remaining_d = remaining_q - (AW+1)'(1);
          if (remaining_q == (AW+1)'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    inflight_d      = re;
    inflight_last_d = re && (remaining_q == (AW+1)'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      cur_addr_q      <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cur_addr_q      <= cur_addr_d;
      remaining_q     <= remaining_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  assign wr_entry.last = inflight_last_q;
  assign wr_entry.data = dout;

  sa_rd_obuf #(
    .DEPTH (OBUF_DEPTH),
    .W     ($bits(obuf_entry_t)),
    .CW    (CW)
  ) u_obuf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i (wr_entry),
    .pop_i       (pop),
    .count_o     (count),
    .head_o      (rd_entry)
  );

  assign ra        = cur_addr_q;
  assign out_valid = (count != '0);
  assign out_data  = rd_entry.data;
  assign out_last  = rd_entry.last && out_valid;
  assign busy      = (state_q != IDLE) || inflight_q || out_valid;
endmodule

// File: tb/tb_sa_ram_rd_ctrl_32x768.sv
// Directed and randomized bench for the burst read sequencer against a RAM model
// and a queue-based expectation of every beat.
module tb_sa_ram_rd_ctrl_32x768;
  localparam int AW = 5;
  localparam int DW = 768;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready;
  logic [AW-1:0] req_addr;
  logic [AW:0]   req_len;
  logic          out_valid, out_ready, out_last, busy, re;
  logic [DW-1:0] out_data, dout;
  logic [AW-1:0] ra;

  sa_ram_rd_ctrl_32x768 dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .ra(ra), .re(re), .dout(dout)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [32];
  always @(posedge clk) if (re) dout <= mem[ra];

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  int            ra_q[$];
  int            tests_run = 0;
  int            failures  = 0;
  int            outstanding = 0;
  int            pops_seen = 0;
  int            phase = 0;
  logic          busy_at_accept;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  beat_t         mon_b;

  task automatic check(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h (low 64b)", tag, obs[63:0], exp[63:0]);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      ra_q.delete();
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      if (re) begin
        if (ra_q.size() == 0) check("re_unexpected", 1, 0);
        else check("ra", ra, ra_q.pop_front());
        outstanding++;
      end
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, prev_data);
        check("stall_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("pop_unexpected", 1, 0);
        else begin
          mon_b = exp_q.pop_front();
          check("data", out_data, mon_b.data);
          check("last", out_last, mon_b.last);
        end
        outstanding--;
        pops_seen++;
      end
      if (re) check("outstanding_le_2", outstanding <= 2, 1);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  // mode 0: ready high; 1: ready pattern 1,0,0,1; 2: random ready
  task automatic step(input int mode);
    @(posedge clk);
    #1;
    case (mode)
      0: out_ready = 1'b1;
      1: out_ready = ((phase % 4) == 0) || ((phase % 4) == 3);
      default: out_ready = ($urandom % 4) != 0;
    endcase
    phase++;
  endtask

  task automatic send_req(input int addr, input int len, input int mode);
    int   n;
    logic acc;
    logic bsy;
    n = (len == 0) ? 32 : len;
    req_addr  = AW'(addr);
    req_len   = (AW+1)'(len);
    req_valid = 1'b1;
    acc = 1'b0;
    bsy = 1'b0;
    for (int k = 0; k < 300; k++) begin
      acc = req_ready;
      bsy = busy;
      step(mode);
      if (acc) break;
    end
    req_valid = 1'b0;
    if (!acc) check("req_timeout", 0, 1);
    else begin
      busy_at_accept = bsy;
      for (int i = 0; i < n; i++) begin
        ra_q.push_back((addr + i) % 32);
        exp_q.push_back('{data: mem[(addr + i) % 32], last: (i == n - 1)});
      end
    end
  endtask

  task automatic drain(input int mode);
    int k;
    k = 0;
    while ((exp_q.size() > 0 || busy) && k < 600) begin
      step(mode);
      k++;
    end
    if (k >= 600) check("drain_timeout", 0, 1);
  endtask

  initial begin
    int p0;
    int k;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0; out_ready = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = {24{32'(i)}};
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_re", re, 0);
    check("rst_ra", ra, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    #1;
    check("idle_req_ready", req_ready, 1);

    // addr 0 len 4: latency and 4 consecutive reads
    send_req(0, 4, 0);
    check("t1_re_T1", re, 1);
    step(0);
    check("t1_re_T2", re, 1);
    check("t1_valid_T2", out_valid, 0);
    step(0);
    check("t1_re_T3", re, 1);
    check("t1_valid_T3", out_valid, 1);
    check("t1_data_T3", out_data, mem[0]);
    step(0);
    check("t1_re_T4", re, 1);
    drain(0);
    $display("[TB] burst addr=0 len=4 done, pops=%0d", pops_seen);

    send_req(30, 4, 0);
    drain(0);
    $display("[TB] burst addr=30 len=4 (wrap) done, pops=%0d", pops_seen);

    p0 = pops_seen;
    send_req(5, 0, 0);
    drain(0);
    check("t3_beats32", pops_seen - p0, 32);
    $display("[TB] burst addr=5 len=0 done, beats=%0d", pops_seen - p0);

    p0 = pops_seen;
    send_req(8, 6, 1);
    drain(1);
    check("t4_beats6", pops_seen - p0, 6);
    $display("[TB] burst addr=8 len=6 with stalls done");

    send_req(0, 2, 0);
    send_req(16, 2, 0);
    check("t5_accept_while_draining", busy_at_accept, 1);
    drain(0);
    $display("[TB] back-to-back bursts 0/16 done");

    p0 = pops_seen;
    send_req(20, 10, 0);
    k = 0;
    while (pops_seen < p0 + 3 && k < 100) begin step(0); k++; end
    if (k >= 100) check("t6_wait_timeout", 0, 1);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_re", re, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_last", out_last, 0);
    exp_q.delete();
    ra_q.delete();
    step(0);
    step(0);
    rst = 1'b0;
    #1;
    p0 = pops_seen;
    send_req(2, 1, 0);
    drain(0);
    check("t6_post_rst_beats", pops_seen - p0, 1);
    $display("[TB] reset mid-burst then addr=2 len=1 done");

    for (int g = 0; g < 8; g++) begin
      for (int i = 0; i < 32; i++)
        for (int w = 0; w < DW / 32; w++) mem[i][w*32 +: 32] = $urandom;
      for (int r = 0; r < 5; r++) begin
        send_req($urandom % 32, $urandom % 33, 2);
        $display("[TB] random req group=%0d idx=%0d addr=%0d len=%0d", g, r, req_addr, req_len);
      end
      drain(2);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end
endmodule

// File: doc/sa_ram_rd_ctrl_32x768.md
Name: sa_ram_rd_ctrl_32x768

Overview:
- Read-side sequencer for the 32-entry x 768-bit two-port scratch RAM (registered read address; dout = M[ra_d]).
- Accepts burst read requests (start address, length), drives the RAM ra/re port, and captures dout into a small output buffer.
- Delivers words on a valid/ready stream with an end-of-burst marker.
- Sits between the RAM read port and the downstream systolic-array feeder; the write port is owned by a separate writer.

Parameters:
- AW, 5, RAM address width (depth 2^AW = 32).
- DW, 768, RAM data width.
- OBUF_DEPTH, 2, output buffer entries (minimum 2 for full throughput).

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous reset, active-high
- req_valid  input  1  burst request valid
- req_ready  output  1  request accepted when req_valid && req_ready
- req_addr  input  AW  start address
- req_len  input  AW+1  beat count 1..32; 0 encodes 32
- out_valid  output  1  output word valid
- out_ready  input  1  downstream accepts word
- out_data  output  DW  RAM word
- out_last  output  1  final beat of burst
- busy  output  1  burst issuing, read in flight, or buffer non-empty
- ra  output  AW  RAM read address
- re  output  1  RAM read enable
- dout  input  DW  RAM read data (valid the cycle after re)

Behaviour:
- Reset (async, rst=1): FSM=IDLE, count=0, inflight=0, buffer empty.
  - Output reset values: req_ready=0 while rst is high, then 1 in IDLE; out_valid=0, out_last=0, out_data=0, re=0, ra=0, busy=0.
- FSM IDLE:
  - req_ready=1.
  - On accept: latch cur_addr=req_addr and remaining=(req_len==0 ? 32 : req_len), then go to ISSUE.
- FSM ISSUE:
  - req_ready=0.
  - re=1 when credit is available; ra=cur_addr.
  - Per re: cur_addr increments mod 32 (31 wraps to 0) and remaining decrements.
  - When re issues with remaining==1, return to IDLE next cycle. Back-to-back bursts are allowed while the buffer drains.
- Credit: re is asserted when (count + inflight) < OBUF_DEPTH, or when a pop occurs this cycle (out_valid && out_ready).
- inflight:
  - Register = re of the previous cycle.
  - Carries a last flag = (remaining==1 at issue).
- Capture: when inflight=1, dout is written into the buffer tail with its last flag in that same cycle.
  - Capture never overflows, because credit guarantees a free slot.
- Latency: request accepted in cycle T -> re in T+1 -> capture at end of T+2 -> out_valid in T+3.
- Throughput: 1 word/cycle with out_ready held high.
- Output stream:
  - out_valid = count>0; head entry drives out_data/out_last.
  - Pop on out_valid && out_ready; capture and pop may occur in the same cycle.
  - out_data/out_last are held stable while out_valid && !out_ready.
- Backpressure: with out_ready=0, at most OBUF_DEPTH reads are outstanding; re stays low until a pop.
- Ordering: words leave in issue order; bursts never interleave.
- Hazard: a RAM write to the address being read, landing before the capture cycle, is visible in the captured word. Write/read ordering is the writer's responsibility; no bypass or hazard check is provided.
- busy = (FSM!=IDLE) || inflight || count>0.
- Reset mid-burst: all state is cleared immediately and the in-flight read is discarded. No partial out_last is produced.

Decomposition:
- Shared package sa_ram_pkg:
  - constants SA_RAM_AW=5, SA_RAM_DW=768;
  - FSM state enum {IDLE, ISSUE};
  - typedef for the buffer entry {last, data}.
- Sub-module sa_rd_obuf: a parameterised OBUF_DEPTH-entry FIFO (push/pop/count, simultaneous push+pop).
- The top module holds the FSM, address/length counters, credit and inflight logic.

Test Plan:
- Preload M[i]=i replicated; request addr=0 len=4, out_ready=1 -> out_valid in cycles T+3..T+6, data 0,1,2,3; out_last only on data 3; re high 4 consecutive cycles.
- Request addr=30 len=4 -> ra sequence 30,31,0,1; outputs 30,31,0,1; last on 1.
- Request addr=5 len=0 -> exactly 32 beats covering addresses 5..31,0..4; out_last on address 4.
- Request addr=8 len=6, out_ready toggling 1,0,0,1,...:
  - never more than 2 reads outstanding;
  - re deasserted while stalled;
  - data 8..13 in order, stable while stalled.
- Two back-to-back requests (addr=0 len=2, then addr=16 len=2), second accepted while first drains -> outputs 0,1,16,17; out_last on 1 and 17.
- Assert rst mid-burst (after 3 beats of len=10) -> out_valid, re, and busy drop to 0 immediately. A new request addr=2 len=1 then returns word 2 with out_last=1.
